arb_mux_ctrl: RTL



---
 rtl/arb_mux_ctrl_pkg.sv | 19 +
 rtl/rr_pick.sv | 32 +++
 rtl/arb_mux_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/arb_mux_ctrl_pkg.sv
// Shared types and helpers for the round-robin mux controller.
// State encodings and the width function for sel/ptr.
package arb_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority search: first set req bit
// strictly after ptr, wrapping around to ptr itself.
module rr_pick
  import arb_mux_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [clog2(N)-1:0] ptr,
  output logic                found,
  output logic [clog2(N)-1:0] idx
);

  localparam int SW = clog2(N);

  logic [SW-1:0] cand;

  // Scan farthest offset first so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = ptr + SW'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arb_mux_ctrl.sv
// Round-robin, burst-limited grant controller
// driving the select of a shared W-bit output mux.
module arb_mux_ctrl
  import arb_mux_ctrl_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      data_in,
  input  logic                out_ready,
  output logic [N-1:0]        gnt,
  output logic [clog2(N)-1:0] sel,
  output logic [W-1:0]        y,
  output logic                y_valid,
  output logic                busy
);

  localparam int SW = clog2(N);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          found;
  logic [SW-1:0] idx;
  logic          beat;
  logic          last;
  logic          rel;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (idx)
  );

  assign busy    = (state_q == ARB_GRANT);
  assign y_valid = busy & req[sel_q];
  assign y       = busy ? data_in[int'(sel_q)*W +: W] : '0;
  assign gnt     = gnt_q;
  assign sel     = sel_q;

  assign beat = y_valid & out_ready;
  assign last = (cnt_q == 4'(MAX_BURST - 1));
  assign rel  = busy & (~req[sel_q] | (beat & last));

  always_comb begin
    state_d = ARB_IDLE;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_GRANT: begin
        if (rel) begin
          state_d = ARB_IDLE;
          ptr_d   = sel_q;
          gnt_d   = '0;
        end else begin
          state_d = ARB_GRANT;
          if (beat) cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        gnt_d = '0;
        if (found) begin
          state_d    = ARB_GRANT;
          gnt_d[idx] = 1'b1;
          sel_d      = idx;
          cnt_d      = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
